// File: rtl/scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_driver
// Brief    : Serial load/unload master for a single scan chain, with an
//            optional single functional capture cycle between the two shifts.
// Revision : 1.0
// ============================================================================
module scan_chain_driver #(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 CP,
    input  logic                 CD,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CHAIN_LEN-1:0] req_data,
    input  logic                 req_capture,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 busy
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_shift1 = 3'd1;
    localparam logic [2:0] c_capt   = 3'd2;
    localparam logic [2:0] c_shift2 = 3'd3;
    localparam logic [2:0] c_resp   = 3'd4;

    localparam logic [CW-1:0] c_last = CW'(CHAIN_LEN - 1);

    logic [2:0]           r_state;
    logic [CHAIN_LEN-1:0] r_tx;
    logic [CHAIN_LEN-1:0] r_rx;
    logic [CW-1:0]        r_cnt;
    logic                 r_cap;
    logic                 r_se;
    logic                 r_rsp_valid;
    logic                 r_busy;
    logic                 r_idle;
    logic [CHAIN_LEN-1:0] w_rx_next;

    // Scan-out enters at bit 0, so after L shifts bit i holds flop i.
    generate
        if (CHAIN_LEN == 1) begin : g_rx_single
            assign w_rx_next = scan_so;
        end else begin : g_rx_multi
            assign w_rx_next = {r_rx[CHAIN_LEN-2:0], scan_so};
        end
    endgenerate

    always_ff @(posedge CP) begin
        if (CD) begin
            r_state     <= c_idle;
            r_tx        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_cap       <= 1'b0;
            r_se        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req_valid && r_idle) begin
                        r_tx    <= req_data;
                        r_cap   <= req_capture;
                        r_cnt   <= '0;
                        r_se    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_idle  <= 1'b0;
                        r_state <= c_shift1;
                    end
                end
                c_shift1: begin
                    r_tx <= r_tx << 1;
                    r_rx <= w_rx_next;
                    if (r_cnt == c_last) begin
                        r_cnt <= '0;
                        r_se  <= 1'b0;
                        if (r_cap) begin
                            r_state <= c_capt;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= c_resp;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                c_capt: begin
                    r_cnt   <= '0;
                    r_se    <= 1'b1;
                    r_state <= c_shift2;
                end
                c_shift2: begin
                    r_rx <= w_rx_next;
                    if (r_cnt == c_last) begin
                        r_cnt       <= '0;
                        r_se        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_resp;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                c_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_idle      <= 1'b1;
                        r_state     <= c_idle;
                    end
                end
                default: begin
                    r_se        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_idle      <= 1'b1;
                    r_state     <= c_idle;
                end
            endcase
        end
    end

    // tx drains to all-zero by the end of the first shift, so its MSB is
    // already the required 0 in every non-SHIFT1 state.
    assign scan_si   = r_tx[CHAIN_LEN-1];
    assign scan_se   = r_se;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rx;
    assign busy      = r_busy;
    assign req_ready = r_idle & ~CD;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_driver
// Brief    : Self-checking bench for scan_chain_driver on an 8-flop chain.
// Revision : 1.0
// ============================================================================
module tb_scan_chain_driver;

    localparam int L = 8;

    logic         CP = 1'b0;
    logic         CD = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [L-1:0] req_data = '0;
    logic         req_capture = 1'b0;
    logic         scan_se;
    logic         scan_si;
    logic         scan_so;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [L-1:0] rsp_data;
    logic         busy;

    logic [L-1:0] chain = '0;
    logic         pre_en = 1'b0;
    logic [L-1:0] pre_val = '0;
    logic         d_en = 1'b0;
    logic [L-1:0] d_val = '0;

    int n_tests = 0;
    int n_fail  = 0;

    scan_chain_driver #(.CHAIN_LEN(L)) dut (
        .CP          (CP),
        .CD          (CD),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_capture (req_capture),
        .scan_se     (scan_se),
        .scan_si     (scan_si),
        .scan_so     (scan_so),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    always #5 CP = ~CP;

    // Behavioural scan chain: CDN tied high, D is either a bench value or hold.
    always @(posedge CP) begin
        if (pre_en)       chain <= pre_val;
        else if (scan_se) chain <= {chain[L-2:0], scan_si};
        else if (d_en)    chain <= d_val;
    end
    assign scan_so = chain[L-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic preload(input logic [L-1:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
    endtask

    // One full transaction; expected values come from the chain-level rules:
    // no capture returns the prior chain and leaves the pattern in it,
    // capture returns the D value and leaves the chain flushed to zero.
    task automatic do_req(input string tag, input logic [L-1:0] data, input logic cap,
                          input logic [L-1:0] dval, input int hold,
                          input logic [L-1:0] exp_rsp, input logic [L-1:0] exp_chain);
        logic [31:0] se_obs, si_obs, se_exp, si_exp;
        int lat, exp_lat, k;
        se_obs = '0; si_obs = '0; se_exp = '0; si_exp = '0;
        lat = -1;
        exp_lat = cap ? 2 * L + 1 : L;
        for (int b = 0; b < L; b++) begin
            se_exp[b] = 1'b1;
            si_exp[b] = data[L-1-b];
            if (cap) se_exp[L+1+b] = 1'b1;
        end
        req_data = data; req_capture = cap; req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin tick(); k++; end
        check({tag, " ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        d_val = dval;
        d_en  = cap;
        for (int e = 0; e < 40; e++) begin
            if (rsp_valid === 1'b1) begin lat = e; break; end
            se_obs[e] = scan_se;
            si_obs[e] = scan_si;
            tick();
        end
        d_en = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " se pattern"}, se_obs, se_exp);
        check({tag, " si pattern"}, si_obs, si_exp);
        check({tag, " se low in resp"}, scan_se, 0);
        check({tag, " rsp_data"}, rsp_data, exp_rsp);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_data  = L'($urandom);
            tick();
            check({tag, " hold valid"}, rsp_valid, 1);
            check({tag, " hold data"}, rsp_data, exp_rsp);
            check({tag, " hold ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " valid drop"}, rsp_valid, 0);
        check({tag, " idle ready"}, req_ready, 1);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " chain after"}, chain, exp_chain);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [L-1:0] pre, dat, dv;
        logic         cap;
        int           k, seen;

        // Reset
        CD = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            check("rst se", scan_se, 0);
            check("rst si", scan_si, 0);
            check("rst rsp_valid", rsp_valid, 0);
            check("rst busy", busy, 0);
            check("rst req_ready", req_ready, 0);
            check("rst rsp_data", rsp_data, 0);
        end
        CD = 1'b0;
        @(negedge CP);
        check("rst release ready", req_ready, 1);
        tick();

        // Load/unload and capture directed cases
        preload(8'hA5);
        do_req("load", 8'h3C, 1'b0, 8'h00, 0, 8'hA5, 8'h3C);
        do_req("capt", 8'hFF, 1'b1, 8'h5A, 0, 8'h5A, 8'h00);

        // Backpressure with req_valid pulses while the response waits
        preload(8'hC3);
        do_req("bp", 8'h81, 1'b0, 8'h00, 5, 8'hC3, 8'h81);

        // Reset in the middle of SHIFT1
        req_data = 8'h77; req_capture = 1'b0; req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin tick(); k++; end
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        CD = 1'b1;
        tick();
        check("midrst se", scan_se, 0);
        check("midrst busy", busy, 0);
        check("midrst valid", rsp_valid, 0);
        CD = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        check("midrst no rsp", seen, 0);
        preload(8'h0F);
        do_req("after rst", 8'h66, 1'b0, 8'h00, 1, 8'h0F, 8'h66);

        // Back-to-back with rsp_ready tied high
        preload(8'h96);
        rsp_ready = 1'b1; req_capture = 1'b0; req_data = 8'h11; req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin tick(); k++; end
        tick();
        req_data = 8'h22;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 50) begin tick(); k++; end
        check("b2b rsp1 valid", rsp_valid, 1);
        check("b2b rsp1 data", rsp_data, 8'h96);
        tick();
        check("b2b hs ready", req_ready, 1);
        check("b2b hs busy", busy, 0);
        tick();
        check("b2b second accept", {busy, scan_se, scan_si}, 3'b110);
        req_valid = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 50) begin tick(); k++; end
        check("b2b rsp2 valid", rsp_valid, 1);
        check("b2b rsp2 data", rsp_data, 8'h11);
        tick();
        rsp_ready = 1'b0;
        check("b2b chain", chain, 8'h22);

        // Randomized transactions against the chain-level model
        for (int i = 0; i < 10; i++) begin
            pre = L'($urandom);
            dat = L'($urandom);
            dv  = L'($urandom);
            cap = 1'($urandom_range(0, 1));
            preload(pre);
            do_req("rand", dat, cap, dv, $urandom_range(0, 3),
                   cap ? dv : pre, cap ? 8'h00 : dat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
